// File: rtl/exe_muldiv_sequencer_if.sv
// Handshake and data bundle between the Execute stage and the RV32M sequencer.
// The master side is the pipeline; the slave side is the sequencer.
interface exe_muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_exe;
  logic [2:0]      funct3_exe;
  logic [XLEN-1:0] op_a_exe;
  logic [XLEN-1:0] op_b_exe;
  logic            flush_exe;
  logic            stall_pipe;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] muldiv_result;

  modport master (
    output start_exe, funct3_exe, op_a_exe, op_b_exe, flush_exe,
    input  stall_pipe, busy, done, muldiv_result
  );

  modport slave (
    input  start_exe, funct3_exe, op_a_exe, op_b_exe, flush_exe,
    output stall_pipe, busy, done, muldiv_result
  );
endinterface

// File: rtl/exe_muldiv_sequencer.sv
// Multi-cycle RV32M sequencer beside the EX ALU: radix-2 shift-add multiply and
// restoring divide on magnitudes, with sign fix-up on the final iteration.
module exe_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic                  clk,
  input logic                  rst,
  exe_muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        funct3_q;
  logic              q_neg;
  logic              a_neg_q;
  logic [5:0]        count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   result_q;

  // Entry decode: which operands are signed, and the shortcut divide results
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] special_result;

  assign a_signed = (bus.funct3_exe == 3'b001) | (bus.funct3_exe == 3'b010) |
                    (bus.funct3_exe[2] & ~bus.funct3_exe[0]);
  assign b_signed = (bus.funct3_exe == 3'b001) |
                    (bus.funct3_exe[2] & ~bus.funct3_exe[0]);
  assign a_neg    = a_signed & bus.op_a_exe[XLEN-1];
  assign b_neg    = b_signed & bus.op_b_exe[XLEN-1];
  assign a_mag_in = a_neg ? -bus.op_a_exe : bus.op_a_exe;
  assign b_mag_in = b_neg ? -bus.op_b_exe : bus.op_b_exe;

  assign div_by_zero = (bus.op_b_exe == '0);
  assign div_ovf     = ~bus.funct3_exe[0] & (bus.op_a_exe == INT_MIN) &
                       (bus.op_b_exe == {XLEN{1'b1}});
  assign special_result = div_by_zero ?
                          (bus.funct3_exe[1] ? bus.op_a_exe : {XLEN{1'b1}}) :
                          (bus.funct3_exe[1] ? '0 : INT_MIN);

  // One iteration step and the sign fix-up of its outcome
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shifted;
  logic [XLEN-1:0]   div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fixup;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    div_shifted = acc[2*XLEN-1:XLEN-1];
    div_ge      = (div_shifted >= {1'b0, b_mag});
    div_sub     = div_shifted[XLEN-1:0] - b_mag;
    if (state == S_DIV)
      acc_next = {(div_ge ? div_sub : div_shifted[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};

    prod  = q_neg ? -acc_next : acc_next;
    quo   = q_neg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem   = a_neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    if (funct3_q[2])
      fixup = funct3_q[1] ? rem : quo;
    else
      fixup = (funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      funct3_q <= '0;
      q_neg    <= 1'b0;
      a_neg_q  <= 1'b0;
      count    <= '0;
      acc      <= '0;
      b_mag    <= '0;
      result_q <= '0;
    end else if (bus.flush_exe) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_exe) begin
            funct3_q <= bus.funct3_exe;
            q_neg    <= a_neg ^ b_neg;
            a_neg_q  <= a_neg;
            count    <= '0;
            acc      <= {{XLEN{1'b0}}, a_mag_in};
            b_mag    <= b_mag_in;
            if (!bus.funct3_exe[2]) begin
              state <= S_MUL;
            end else if (div_by_zero | div_ovf) begin
              result_q <= special_result;
              state    <= S_DONE;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc   <= acc_next;
          count <= count + 6'd1;
          if (count == 6'(XLEN-1)) begin
            result_q <= fixup;
            state    <= S_DONE;
          end
        end
        // The finishing instruction is still visible in EX, so start_exe is ignored here
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_pipe    = ~bus.flush_exe & (((state == S_IDLE) & bus.start_exe) |
                                               (state == S_MUL) | (state == S_DIV));
  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = (state == S_DONE);
  assign bus.muldiv_result = result_q;

endmodule

// File: tb/tb_exe_muldiv_sequencer.sv
// Directed-vector bench for the RV32M sequencer: table of ops with hand-computed
// results and latencies, plus abort and mid-operation reset sequences.
module tb_exe_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  exe_muldiv_sequencer_if #(.XLEN(32)) bus ();

  exe_muldiv_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Start one op on the negedge of cycle T, then scramble operands and funct3
  // to prove they were sampled at the end of T.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int          done_at;
    bit          stall_bad;
    logic [31:0] res;
    done_at   = 0;
    stall_bad = 0;
    res       = 'x;
    @(negedge clk);
    bus.start_exe  = 1'b1;
    bus.funct3_exe = f3;
    bus.op_a_exe   = a;
    bus.op_b_exe   = b;
    #1;
    check({name, ".stall_T"}, 32'(bus.stall_pipe), 32'd1);
    check({name, ".done_T"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.start_exe  = 1'b0;
    bus.funct3_exe = ~f3;
    bus.op_a_exe   = ~a;
    bus.op_b_exe   = b + 32'd5;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      #1;
      if (bus.done) begin
        done_at = k;
        res     = bus.muldiv_result;
        if (bus.stall_pipe) stall_bad = 1;
      end else begin
        if (!bus.stall_pipe) stall_bad = 1;
        @(negedge clk);
      end
    end
    check({name, ".done_cycle"}, 32'(done_at), 32'(lat));
    check({name, ".result"}, res, exp);
    check({name, ".stall_window"}, 32'(stall_bad), 32'd0);
    @(negedge clk);
    #1;
    check({name, ".busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"mul_7_m3",        3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{"mulh_min_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{"mulhsu_min_min",  3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33};
    vecs[3]  = '{"mulhu_min_min",   3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[4]  = '{"mulh_m1_m1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[5]  = '{"mulhsu_m1_2",     3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{"mulhu_max_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[7]  = '{"div_m7_2",        3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[8]  = '{"rem_m7_2",        3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[9]  = '{"divu_100_7",      3'b101, 32'd100,       32'd7,         32'd14,        33};
    vecs[10] = '{"remu_100_7",      3'b111, 32'd100,       32'd7,         32'd2,         33};
    vecs[11] = '{"div_7_m2",        3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[12] = '{"rem_7_m2",        3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[13] = '{"divu_by_zero",    3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[14] = '{"rem_by_zero",     3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
    vecs[15] = '{"div_overflow",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};

    bus.start_exe  = 1'b0;
    bus.funct3_exe = 3'b000;
    bus.op_a_exe   = '0;
    bus.op_b_exe   = '0;
    bus.flush_exe  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.busy",   32'(bus.busy), 32'd0);
    check("reset.done",   32'(bus.done), 32'd0);
    check("reset.stall",  32'(bus.stall_pipe), 32'd0);
    check("reset.result", bus.muldiv_result, 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    run_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Abort: DIV started at T, flush at T+10, new MUL at T+12 finishing at T+45
    begin
      bit done_seen;
      bit stall_lost;
      done_seen  = 0;
      stall_lost = 0;
      @(negedge clk);
      bus.start_exe  = 1'b1;
      bus.funct3_exe = 3'b100;
      bus.op_a_exe   = 32'd1000;
      bus.op_b_exe   = 32'd3;
      @(negedge clk);
      bus.start_exe = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        #1;
        if (bus.done) done_seen = 1;
        if (!bus.stall_pipe) stall_lost = 1;
        @(negedge clk);
      end
      bus.flush_exe = 1'b1;
      #1;
      check("abort.stall_flush", 32'(bus.stall_pipe), 32'd0);
      check("abort.busy_flush",  32'(bus.busy), 32'd1);
      if (bus.done) done_seen = 1;
      @(negedge clk);
      bus.flush_exe = 1'b0;
      #1;
      check("abort.busy_after",  32'(bus.busy), 32'd0);
      if (bus.done) done_seen = 1;
      check("abort.done_never",  32'(done_seen), 32'd0);
      check("abort.stall_held",  32'(stall_lost), 32'd0);
    end
    run_op("abort.next_mul", 3'b000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 33);

    // Reset mid-op: MUL started at T, rst at T+5, everything cleared at T+6
    @(negedge clk);
    bus.start_exe  = 1'b1;
    bus.funct3_exe = 3'b000;
    bus.op_a_exe   = 32'd9;
    bus.op_b_exe   = 32'd9;
    @(negedge clk);
    bus.start_exe = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid.busy",   32'(bus.busy), 32'd0);
    check("rst_mid.done",   32'(bus.done), 32'd0);
    check("rst_mid.stall",  32'(bus.stall_pipe), 32'd0);
    check("rst_mid.result", bus.muldiv_result, 32'd0);

    run_op("post_rst_mul", 3'b000, 32'd9, 32'd9, 32'd81, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_sequencer.md
# exe_muldiv_sequencer

Multi-cycle multiply/divide sequencer attached beside the Execute stage ALU, implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It takes the post-forwarding EX operands and iterates a radix-2 shift-add multiplier or a restoring divider. While the operation runs it holds the IF/ID/EX pipeline through a stall request. In the final cycle it presents the result so the instruction advances to MEM with it in place of the ALU result.

## Interface

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_exe  input  1  a valid M-extension instruction occupies EX.
- funct3_exe  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_exe  input  XLEN  rs1 operand after the forwarding mux.
- op_b_exe  input  XLEN  rs2 operand after the forwarding mux.
- flush_exe  input  1  kill the EX instruction; aborts any operation in progress.
- stall_pipe  output  1  hold PC, IF/ID and ID/EX registers this cycle.
- busy  output  1  state is not IDLE.
- done  output  1  result is valid this cycle; EX/MEM captures it at the end of the cycle.
- muldiv_result  output  XLEN  registered result.

## Operation

- FSM states: IDLE, MUL, DIV, DONE.
- **IDLE**
  - If start_exe=1 and flush_exe=0, latch funct3 and the operand magnitudes and signs, and clear the 6-bit iteration counter.
  - funct3[2]=0 goes to MUL.
  - funct3[2]=1 goes to DIV, except in the special cases below.
- **DIV special cases:** these load muldiv_result directly and go to DONE without iterating.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF. REM/REMU give op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- **Signedness**
  - Signed operands: MULH treats both as signed. MULHSU treats a as signed, b as unsigned. DIV/REM treat both as signed.
  - MUL uses the same unsigned magnitude path; its low 32 bits are sign-agnostic.
  - Negative signed operands are converted to magnitude on entry.
- **MUL**
  - One shift-add step per cycle on a 64-bit accumulator: 32 cycles.
  - On exit, negate the 64-bit product if the result sign is a_sign XOR b_sign.
  - Result is [31:0] for MUL and [63:32] for the others.
- **DIV**
  - One restoring step per cycle, producing a 32-bit quotient and a 33-bit partial remainder: 32 cycles.
  - Quotient sign is a_sign XOR b_sign. Remainder sign is a_sign.
  - Result is the quotient for DIV/DIVU and the remainder for REM/REMU.
- MUL/DIV move to DONE when the counter reaches 31; the fix-up result is written to muldiv_result on that edge.
- **DONE**: done=1 and stall_pipe=0. Next state is always IDLE. start_exe is ignored in DONE, because the same instruction is still visible in EX.
- **Outputs**
  - stall_pipe = ~flush_exe & ((IDLE & start_exe) | MUL | DIV).
  - busy = ~IDLE.
  - done = DONE.
- **flush_exe**: in any state, next state is IDLE, the counter clears, and done never asserts for the aborted op. flush_exe has priority over start_exe.
- **Reset (rst=1)**: next state IDLE. muldiv_result, counter and all internal registers go to 0. stall_pipe, busy and done read 0 from the following cycle. Reset during MUL/DIV/DONE discards the operation.
- muldiv_result holds its last value outside DONE. It is only guaranteed valid while done=1.

## Timing

Start accepted in cycle T (IDLE, start_exe=1):
- **Iterating op**
  - stall_pipe=1 in T through T+32.
  - MUL/DIV occupies T+1 through T+32.
  - DONE is T+33 (done=1, stall_pipe=0).
  - Back in IDLE at T+34.
  - Total EX occupancy is 34 cycles.
- **Special-case divide**
  - stall_pipe=1 in T only.
  - DONE is T+1.
- **Operand sampling**: operands are sampled once, at the end of T. Later changes on op_a_exe/op_b_exe (for example forwarding sources retiring) have no effect.
- **Back-to-back M ops**: the second is seen at IDLE in T+34 at the earliest. There is no dead cycle beyond the DONE cycle.
- **Timing of stall_pipe**: stall_pipe is combinational from start_exe and flush_exe. The hazard unit ORs it with the load-use stall.

## Test plan

- MUL 7 × 0xFFFFFFFD (-3) at T: stall_pipe=1 in T..T+32, done=1 only at T+33, muldiv_result=0xFFFFFFEB. busy=0 at T+34.
- MULH/MULHSU/MULHU with a=b=0x80000000:
  - MULH gives 0x40000000.
  - MULHU gives 0x40000000.
  - MULHSU gives 0xC0000000.
  - MULH 0xFFFFFFFF × 0xFFFFFFFF gives 0x00000000.
- Divides:
  - DIV 0xFFFFFFF9 (-7) / 2 gives 0xFFFFFFFD.
  - REM gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14.
  - REMU gives 2.
  - Each case has done at T+33.
- Special divides, each with done at T+1 and stall_pipe high in T only:
  - DIVU 0x1234/0 gives 0xFFFFFFFF.
  - REM 0x1234/0 gives 0x1234.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM with the same operands gives 0.
- Abort: start DIV at T and assert flush_exe at T+10. stall_pipe=0 in T+10, IDLE at T+11, done never asserts. A new MUL started at T+12 completes correctly at T+45.
- Reset mid-op: start MUL at T and assert rst at T+5. At T+6, busy=0, done=0, stall_pipe=0 (with start_exe low), and muldiv_result=0.
